// File: rtl/corefifo_gray_conv_pipe.sv
// Pipelined gray<->binary converter with valid/ready handshake, used for FIFO pointer conversion.
// Gray-to-binary words are also checked for multi-bit steps against the previous gray input.
module corefifo_gray_conv_pipe #(
    parameter int ADDRWIDTH    = 3,
    parameter int PIPE_STAGES  = 2,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [ADDRWIDTH:0]      in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRWIDTH:0]      out_data,
    output logic                    out_mode,
    output logic                    out_err,
    output logic [ERRCNT_WIDTH-1:0] err_count,
    input  logic                    err_clr
);

    localparam int W     = ADDRWIDTH + 1;
    localparam int CHUNK = (W + PIPE_STAGES - 1) / PIPE_STAGES;

    // Resolves this stage's slice of the gray-to-binary prefix chain in place, MSB first;
    // bits above the slice are already binary, bits below are still gray.
    function automatic logic [W-1:0] resolveChunk(input logic [W-1:0] d, input int stage);
        logic [W-1:0] r;
        int           hi;
        int           lo;
        r  = d;
        hi = W - 1 - stage * CHUNK;
        lo = W - (stage + 1) * CHUNK;
        for (int i = W - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                r[i] = r[i+1] ^ r[i];
            end
        end
        return r;
    endfunction

    logic [PIPE_STAGES-1:0]  valid_q;
    logic [PIPE_STAGES-1:0]  valid_d;
    logic [PIPE_STAGES-1:0]  mode_q;
    logic [PIPE_STAGES-1:0]  mode_d;
    logic [PIPE_STAGES-1:0]  err_q;
    logic [PIPE_STAGES-1:0]  err_d;
    logic [W-1:0]            data_q [PIPE_STAGES];
    logic [W-1:0]            data_d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]  load;
    logic                    loadChain;

    logic [W-1:0]            prevGray_q;
    logic [W-1:0]            prevGray_d;
    logic                    seen_q;
    logic                    seen_d;
    logic [W-1:0]            stepDiff;
    logic                    multiBit;
    logic                    accept;

    logic [ERRCNT_WIDTH-1:0] errCount_q;
    logic [ERRCNT_WIDTH-1:0] errCount_d;
    logic                    errInc;

    // A stage loads when empty or when its occupant moves on; evaluated from the output backwards
    always_comb begin
        load      = '0;
        loadChain = !valid_q[PIPE_STAGES-1] || out_ready;
        load[PIPE_STAGES-1] = loadChain;
        for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
            loadChain = !valid_q[k] || loadChain;
            load[k]   = loadChain;
        end
    end

    assign in_ready = load[0];
    assign accept   = in_valid && load[0];

    // A popcount above one is detected by clearing the lowest set bit and testing for leftovers
    assign stepDiff = in_data ^ prevGray_q;
    assign multiBit = |(stepDiff & (stepDiff - W'(1)));

    always_comb begin
        valid_d    = valid_q;
        mode_d     = mode_q;
        err_d      = err_q;
        prevGray_d = prevGray_q;
        seen_d     = seen_q;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            data_d[k] = data_q[k];
        end

        if (load[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                mode_d[0] = in_mode;
                err_d[0]  = !in_mode && seen_q && multiBit;
                data_d[0] = in_mode ? (in_data ^ (in_data >> 1)) : resolveChunk(in_data, 0);
            end
        end

        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    mode_d[k] = mode_q[k-1];
                    err_d[k]  = err_q[k-1];
                    data_d[k] = mode_q[k-1] ? data_q[k-1] : resolveChunk(data_q[k-1], k);
                end
            end
        end

        if (accept && !in_mode) begin
            prevGray_d = in_data;
            seen_d     = 1'b1;
        end
    end

    // Clear takes priority over a coincident increment; the count sticks at all-ones
    assign errInc = valid_q[PIPE_STAGES-1] && out_ready && err_q[PIPE_STAGES-1];

    always_comb begin
        errCount_d = errCount_q;
        if (err_clr) begin
            errCount_d = '0;
        end else if (errInc && !(&errCount_q)) begin
            errCount_d = errCount_q + ERRCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= '0;
            mode_q     <= '0;
            err_q      <= '0;
            prevGray_q <= '0;
            seen_q     <= 1'b0;
            errCount_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            prevGray_q <= prevGray_d;
            seen_q     <= seen_d;
            errCount_q <= errCount_d;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q[PIPE_STAGES-1];
    assign out_data  = data_q[PIPE_STAGES-1];
    assign out_mode  = mode_q[PIPE_STAGES-1];
    assign out_err   = err_q[PIPE_STAGES-1];
    assign err_count = errCount_q;

endmodule

// File: tb/tb_corefifo_gray_conv_pipe.sv
// Directed self-checking bench for corefifo_gray_conv_pipe (ADDRWIDTH=3, PIPE_STAGES=2, ERRCNT_WIDTH=8).
// Expected results are queued per word and compared as each output is consumed.
module tb_corefifo_gray_conv_pipe;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_mode;
    logic       out_err;
    logic [7:0] err_count;
    logic       err_clr;

    typedef struct packed {
        logic [3:0] data;
        logic       mode;
        logic       err;
    } expWord_t;

    expWord_t expQ[$];
    int       errors;
    int       checks;
    int       cycleCnt;
    int       popCount;
    int       lastPopCycle;

    corefifo_gray_conv_pipe #(
        .ADDRWIDTH   (3),
        .PIPE_STAGES (2),
        .ERRCNT_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_mode (out_mode),
        .out_err  (out_err),
        .err_count(err_count),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled on the falling edge; a valid&&ready seen here transfers on the next rise
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            popCount++;
            lastPopCycle = cycleCnt;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out", 32'(out_data), 32'hDEAD);
            end else begin
                expWord_t e;
                e = expQ.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(e.data));
                checkOutput("out_mode", 32'(out_mode), 32'(e.mode));
                checkOutput("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the word
    task automatic applyStimulus(input logic mode, input logic [3:0] data,
                                 input logic [3:0] expData, input logic expErr);
        logic accepted;
        expWord_t e;
        e.data = expData;
        e.mode = mode;
        e.err  = expErr;
        expQ.push_back(e);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        accepted = 1'b0;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idleInput();
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_data  = 4'd0;
    endtask

    task automatic drainOutputs();
        for (int c = 0; c < 200 && expQ.size() != 0; c++) @(negedge clk);
        if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        idleInput();
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int startCnt;
        int popStart;
        errors   = 0;
        checks   = 0;
        cycleCnt = 0;
        popCount = 0;
        lastPopCycle = 0;
        resetDut();

        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_mode", 32'(out_mode), 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: accepted at the end of cycle N, visible in cycle N+2
        applyStimulus(1'b0, 4'b1101, 4'b1001, 1'b0);
        idleInput();
        @(negedge clk);
        checkOutput("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_data", 32'(out_data), 32'b1001);
        drainOutputs();

        applyStimulus(1'b1, 4'b1001, 4'b1101, 1'b0);
        idleInput();
        drainOutputs();

        // Back-to-back sweep of both modes: 32 results on 32 consecutive cycles
        resetDut();
        startCnt = cycleCnt;
        popStart = popCount;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            applyStimulus(1'b1, v, v ^ (v >> 1), 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            applyStimulus(1'b0, v ^ (v >> 1), v, 1'b0);
        end
        idleInput();
        drainOutputs();
        checkOutput("sweep_count", 32'(popCount - popStart), 32'd32);
        checkOutput("sweep_span", 32'(lastPopCycle - startCnt), 32'd33);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        idleInput();
        drainOutputs();
        checkOutput("sweep_err_count", 32'(err_count), 32'd0);

        // Step check sequence and clear
        resetDut();
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0011, 4'b0010, 1'b0);
        applyStimulus(1'b0, 4'b0011, 4'b0010, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
        idleInput();
        drainOutputs();
        @(negedge clk);
        checkOutput("seq_err_count", 32'(err_count), 32'd1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("clr_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: out_ready low for cycles 3..7 of a six-word stream
        resetDut();
        popStart = popCount;
        fork
            begin
                applyStimulus(1'b1, 4'd1, 4'd1, 1'b0);
                applyStimulus(1'b1, 4'd2, 4'd3, 1'b0);
                applyStimulus(1'b1, 4'd3, 4'd2, 1'b0);
                applyStimulus(1'b1, 4'd4, 4'd6, 1'b0);
                applyStimulus(1'b1, 4'd5, 4'd7, 1'b0);
                applyStimulus(1'b1, 4'd6, 4'd5, 1'b0);
                idleInput();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
                checkOutput("bp_hold_start", 32'(out_data), 32'd3);
                repeat (4) @(posedge clk);
                @(negedge clk);
                checkOutput("bp_in_ready_still", 32'(in_ready), 32'd0);
                checkOutput("bp_hold_end", 32'(out_data), 32'd3);
                checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drainOutputs();
        checkOutput("bp_count", 32'(popCount - popStart), 32'd6);

        // Saturation: one clean word, then 300 three-bit steps
        resetDut();
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'b0, 4'b0111, 4'b0101, 1'b1);
            applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
        end
        idleInput();
        drainOutputs();
        @(negedge clk);
        checkOutput("sat_err_count", 32'(err_count), 32'd255);
        @(posedge clk);
        #1;

        // Reset with two words in flight; the seen flag must be cleared too
        resetDut();
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'd1, 4'd1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 4'b0010, 1'b0);
        idleInput();
        @(negedge clk);
        checkOutput("inflight_valid", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_err_count", 32'(err_count), 32'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'b0111, 4'b0101, 1'b0);
        idleInput();
        drainOutputs();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_rst_err_count", 32'(err_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
